// File: rtl/riscv_pkg.sv
// Shared RISC-V load/store definitions: funct3 size encodings, MEM/WB register
// layout and the lane helpers used by the memory stage.
package riscv_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_NONE = 2'd3
  } acc_size_e;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic        reg_write;
    logic        misaligned;
    logic        load_sel;
    logic [1:0]  offset;
    logic [2:0]  funct3;
    logic [31:0] alu;
  } wb_reg_t;

  // Stores have no unsigned variants, so BU/HU encodings are undefined for them.
  function automatic acc_size_e decode_size(input logic [2:0] f3, input logic is_store);
    acc_size_e sz;
    case (f3)
      F3_LB:   sz = SZ_BYTE;
      F3_LH:   sz = SZ_HALF;
      F3_LW:   sz = SZ_WORD;
      F3_LBU:  sz = is_store ? SZ_NONE : SZ_BYTE;
      F3_LHU:  sz = is_store ? SZ_NONE : SZ_HALF;
      default: sz = SZ_NONE;
    endcase
    return sz;
  endfunction

  function automatic logic size_misaligned(input acc_size_e sz, input logic [1:0] off);
    logic bad;
    case (sz)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = off[0];
      SZ_WORD: bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] store_be(input acc_size_e sz, input logic [1:0] off);
    logic [3:0] be;
    case (sz)
      SZ_BYTE: be = 4'b0001 << off;
      SZ_HALF: be = 4'b0011 << off;
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicating the low bits places them on every lane; byte enables pick the right one.
  function automatic logic [31:0] store_lanes(input acc_size_e sz, input logic [31:0] d);
    logic [31:0] w;
    case (sz)
      SZ_BYTE: w = {4{d[7:0]}};
      SZ_HALF: w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] rdata, input logic [2:0] f3,
                                              input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = rdata[{off, 3'b000} +: 8];
    h = off[1] ? rdata[31:16] : rdata[15:0];
    case (f3)
      F3_LB:   r = {{24{b[7]}}, b};
      F3_LH:   r = {{16{h[15]}}, h};
      F3_LBU:  r = {24'd0, b};
      F3_LHU:  r = {16'd0, h};
      default: r = rdata;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// EX->MEM request and MEM/WB result bundle between the execute stage and mem_stage.
interface mem_stage_if;

  logic        valid;
  logic [31:0] alu_result;
  logic [31:0] rs2_data;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic        reg_write;
  logic        stall;

  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic [31:0] wb_data;
  logic        misaligned;

  modport master (
    output valid, alu_result, rs2_data, mem_read, mem_write, funct3, rd, reg_write, stall,
    input  wb_valid, wb_rd, wb_reg_write, wb_data, misaligned
  );

  modport slave (
    input  valid, alu_result, rs2_data, mem_read, mem_write, funct3, rd, reg_write, stall,
    output wb_valid, wb_rd, wb_reg_write, wb_data, misaligned
  );

endinterface

// File: rtl/mem_stage_dmem.sv
// Word-organised data memory: synchronous read, byte-enable write, no reset of contents.
module dmem #(
  parameter int unsigned DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [3:0]               be_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [31:0]              wdata_i,
  output logic [31:0]              rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;
  logic [31:0] mask_s;
  logic [31:0] merged_s;

  // Merge new lanes into the addressed word under the byte-enable mask.
  always_comb begin
    mask_s   = {{8{be_i[3]}}, {8{be_i[2]}}, {8{be_i[1]}}, {8{be_i[0]}}};
    merged_s = (mem_q[addr_i] & ~mask_s) | (wdata_i & mask_s);
  end

  // Array write and read-data register; rdata holds while re_i is low.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= merged_s;
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_stage.sv
// RISC-V MEM stage: address decode, store lane placement, load extraction and the
// MEM/WB pipeline register, with misaligned/undefined accesses flagged and dropped.
module mem_stage
  import riscv_pkg::*;
#(
  parameter int unsigned DMEM_WORDS = 1024
) (
  input logic         clk,
  input logic         rst,
  mem_stage_if.slave  bus
);

  localparam int unsigned AW = $clog2(DMEM_WORDS);

  acc_size_e   size_s;
  logic [1:0]  off_s;
  logic [AW-1:0] idx_s;
  logic        access_s;
  logic        illegal_s;
  logic        store_s;
  logic        load_s;
  logic        we_s;
  logic        re_s;
  logic [3:0]  be_s;
  logic [31:0] wdata_s;
  logic [31:0] rdata_s;
  wb_reg_t     wb_d;
  wb_reg_t     wb_q;

  // Request decode; a simultaneous read+write is treated purely as a store.
  always_comb begin
    off_s     = bus.alu_result[1:0];
    idx_s     = bus.alu_result[AW+1:2];
    access_s  = bus.valid & (bus.mem_read | bus.mem_write);
    size_s    = decode_size(bus.funct3, bus.mem_write);
    illegal_s = access_s & size_misaligned(size_s, off_s);
    store_s   = bus.valid & bus.mem_write & ~illegal_s;
    load_s    = bus.valid & bus.mem_read & ~bus.mem_write & ~illegal_s;
    be_s      = store_be(size_s, off_s);
    wdata_s   = store_lanes(size_s, bus.rs2_data);
  end

  assign we_s = store_s & ~bus.stall & ~rst;
  assign re_s = load_s & ~bus.stall & ~rst;

  dmem #(
    .DEPTH (DMEM_WORDS)
  ) u_dmem (
    .clk     (clk),
    .we_i    (we_s),
    .be_i    (be_s),
    .re_i    (re_s),
    .addr_i  (idx_s),
    .wdata_i (wdata_s),
    .rdata_o (rdata_s)
  );

  // Next MEM/WB contents; load lane/offset are kept so extraction follows the sync read.
  always_comb begin
    wb_d.valid      = bus.valid;
    wb_d.rd         = bus.rd;
    wb_d.reg_write  = bus.valid & bus.reg_write & (bus.rd != 5'd0) & ~illegal_s;
    wb_d.misaligned = illegal_s;
    wb_d.load_sel   = load_s;
    wb_d.offset     = off_s;
    wb_d.funct3     = bus.funct3;
    wb_d.alu        = bus.alu_result;
  end

  // MEM/WB register: reset wins over stall, stall freezes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_q <= '0;
    end else if (!bus.stall) begin
      wb_q <= wb_d;
    end
  end

  assign bus.wb_valid     = wb_q.valid;
  assign bus.wb_rd        = wb_q.rd;
  assign bus.wb_reg_write = wb_q.reg_write;
  assign bus.misaligned   = wb_q.misaligned;
  assign bus.wb_data      = wb_q.load_sel ? load_extend(rdata_s, wb_q.funct3, wb_q.offset)
                                          : wb_q.alu;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a byte-addressed reference memory predicts each
// MEM/WB result, and a separate monitor compares it when the stage advances.
module tb_mem_stage;
  import riscv_pkg::*;

  localparam int unsigned WORDS = 64;
  localparam int unsigned BYTES = WORDS * 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_stage_if bus();

  mem_stage #(.DMEM_WORDS(WORDS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        v;
    logic [4:0]  rd;
    logic        rw;
    logic        mis;
    logic        chk;
    logic [31:0] data;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       last_exp;
  logic [7:0] ref_mem [BYTES];
  int         n_cmp = 0;
  int         n_bad = 0;
  bit         done  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, want, $time);
    end
  endtask

  task automatic compare(input exp_t e);
    check("wb_valid", {31'd0, bus.wb_valid}, {31'd0, e.v});
    check("wb_reg_write", {31'd0, bus.wb_reg_write}, {31'd0, e.rw});
    check("misaligned", {31'd0, bus.misaligned}, {31'd0, e.mis});
    if (e.chk) begin
      check("wb_rd", {27'd0, bus.wb_rd}, {27'd0, e.rd});
      check("wb_data", bus.wb_data, e.data);
    end
  endtask

  // Drive one cycle of inputs; when the stage will advance, predict its output.
  task automatic issue(input logic v, input logic rd_en, input logic wr_en, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                       input logic rw, input logic stl, input logic rs);
    exp_t        e;
    int unsigned ba;
    int unsigned nb;
    bit          ok;
    bit          mis;
    logic [31:0] ld;
    bus.valid = v;  bus.mem_read = rd_en;  bus.mem_write = wr_en;  bus.funct3 = f3;
    bus.alu_result = addr;  bus.rs2_data = wdata;  bus.rd = rd;  bus.reg_write = rw;
    bus.stall = stl;  rst = rs;
    if (rs || !stl) begin
      ba = addr % BYTES;
      if (wr_en) begin
        case (f3)
          3'b000: nb = 1;  3'b001: nb = 2;  3'b010: nb = 4;
          default: nb = 0;
        endcase
      end else begin
        case (f3)
          3'b000, 3'b100: nb = 1;  3'b001, 3'b101: nb = 2;  3'b010: nb = 4;
          default: nb = 0;
        endcase
      end
      ok  = (nb != 0) && (ba % nb == 0);
      mis = v && (rd_en || wr_en) && !ok;
      e.v = v;  e.rd = rd;  e.rw = v && rw && (rd != 5'd0) && !mis;
      e.mis = mis;  e.chk = v;  e.data = addr;
      if (v && rd_en && !wr_en && ok) begin
        ld = 32'd0;
        for (int k = 0; k < nb; k++) ld[8*k +: 8] = ref_mem[ba + k];
        if (f3 == 3'b000) ld = {{24{ld[7]}}, ld[7:0]};
        if (f3 == 3'b001) ld = {{16{ld[15]}}, ld[15:0]};
        e.data = ld;
      end
      if (rs) begin
        e.v = 1'b0;  e.rd = 5'd0;  e.rw = 1'b0;  e.mis = 1'b0;  e.chk = 1'b1;  e.data = 32'd0;
      end else if (v && wr_en && ok) begin
        for (int k = 0; k < nb; k++) ref_mem[ba + k] = wdata[8*k +: 8];
      end
      exp_q.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin : monitor
    bit   adv;
    exp_t e;
    while (1) begin
      @(posedge clk);
      if (done) break;
      adv = rst || !bus.stall;
      #1;
      if (adv) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL scoreboard_underflow: got output with 0 expected entries at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          compare(e);
          last_exp = e;
        end
      end else begin
        compare(last_exp);
      end
    end
  end

  initial begin : driver
    logic [31:0] a;
    logic [2:0]  f;
    logic        v, rdn, wrn, stl, rs;
    int          kind;
    issue(0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0, 0, 0, 1);
    issue(0, 0, 1, F3_SW, 32'h10, 32'h0, 5'd0, 0, 1, 1);
    for (int i = 0; i < WORDS; i++)
      issue(1, 0, 1, F3_SW, i * 4, $urandom, 5'($urandom), 1'($urandom), 0, 0);

    issue(1, 0, 1, F3_SW, 32'h10, 32'hDEADBEEF, 5'd0, 0, 0, 0);
    issue(1, 1, 0, F3_LW, 32'h10, 32'h0, 5'd1, 1, 0, 0);
    issue(1, 0, 1, F3_SW, 32'h10, 32'h11223344, 5'd0, 0, 0, 0);
    issue(1, 0, 1, F3_SB, 32'h13, 32'h000000F0, 5'd0, 0, 0, 0);
    issue(1, 1, 0, F3_LB, 32'h13, 32'h0, 5'd2, 1, 0, 0);
    issue(1, 1, 0, F3_LBU, 32'h13, 32'h0, 5'd3, 1, 0, 0);
    issue(1, 1, 0, F3_LW, 32'h10, 32'h0, 5'd4, 1, 0, 0);
    issue(1, 1, 0, F3_LH, 32'h11, 32'h0, 5'd5, 1, 0, 0);
    issue(1, 1, 0, F3_LHU, 32'h12, 32'h0, 5'd5, 1, 0, 0);
    issue(1, 0, 1, F3_SW, 32'h20, 32'h12345678, 5'd0, 0, 0, 0);
    issue(1, 0, 1, F3_SW, 32'h22, 32'hCAFEF00D, 5'd0, 0, 0, 0);
    issue(1, 1, 0, F3_LW, 32'h20, 32'h0, 5'd6, 1, 0, 0);
    issue(1, 1, 0, 3'b011, 32'h20, 32'h0, 5'd6, 1, 0, 0);
    issue(1, 1, 0, F3_LW, 32'h10, 32'h0, 5'd7, 1, 0, 0);
    for (int i = 0; i < 3; i++) issue(1, 0, 1, F3_SW, 32'h30, 32'h5, 5'd0, 0, 1, 0);
    issue(1, 0, 1, F3_SW, 32'h30, 32'h5, 5'd0, 0, 0, 0);
    issue(1, 1, 0, F3_LW, 32'h30, 32'h0, 5'd8, 1, 0, 0);
    issue(1, 0, 0, 3'b000, 32'h0000000F, 32'h0, 5'd5, 1, 0, 0);
    issue(1, 0, 0, 3'b000, 32'h0000000F, 32'h0, 5'd0, 1, 0, 0);
    issue(0, 0, 1, F3_SW, 32'h10, 32'h0, 5'd9, 1, 0, 0);
    issue(1, 1, 1, F3_SW, 32'h50, 32'h77, 5'd9, 1, 0, 0);
    issue(1, 1, 0, F3_LW, 32'hABCD0050, 32'h0, 5'd10, 1, 0, 0);
    issue(1, 0, 1, F3_SW, 32'h40, 32'hA5A5A5A5, 5'd0, 0, 0, 0);
    issue(1, 0, 1, F3_SW, 32'h40, 32'h0, 5'd0, 0, 0, 1);
    issue(1, 0, 1, F3_SW, 32'h40, 32'h1, 5'd11, 1, 1, 0);
    issue(1, 0, 1, F3_SW, 32'h40, 32'h2, 5'd11, 1, 1, 1);
    issue(1, 1, 0, F3_LW, 32'h40, 32'h0, 5'd12, 1, 0, 0);

    for (int n = 0; n < 500; n++) begin
      v    = ($urandom_range(0, 99) >= 8);
      kind = $urandom_range(0, 9);
      rdn  = (kind <= 3) || (kind == 7);
      wrn  = (kind >= 4) && (kind <= 7);
      f    = 3'($urandom_range(0, 7));
      if (wrn && (f == 3'b100 || f == 3'b101)) f = F3_SW;
      a    = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      stl  = ($urandom_range(0, 99) < 15);
      rs   = ($urandom_range(0, 199) == 0);
      if (stl && !rs) issue(v, rdn, wrn, f, a, $urandom, 5'($urandom), 1'($urandom), 1, 0);
      issue(v, rdn, wrn, f, a, $urandom, 5'($urandom), 1'($urandom), 0, rs);
    end

    done = 1'b1;
    @(posedge clk);
    #2;
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
